// File: rtl/fault_monitor_regs_if.sv
// SPI write-bus bundle feeding the fault/alert register bank.
interface fault_monitor_regs_if;
    logic [31:0] data_mosi;
    logic        data_mosi_rdy;
    logic [15:0] addr;

    modport master (output data_mosi, output data_mosi_rdy, output addr);
    modport slave  (input  data_mosi, input  data_mosi_rdy, input  addr);
endinterface

// File: rtl/fault_monitor_regs.sv
// Fault/alert register bank: synchronised, debounced fault inputs with sticky W1C flags,
// first-fault capture and a maskable level interrupt.
module fault_monitor_regs #(
    parameter int unsigned N_CH            = 16,
    parameter int unsigned DEB_W           = 8,
    parameter int unsigned DEB_CYCLES      = 100,
    parameter logic [15:0] ADDR_FLT_STICKY = 16'h0040,
    parameter logic [15:0] ADDR_FLT_MASK   = 16'h0041,
    parameter logic [15:0] ADDR_FLT_POL    = 16'h0042,
    parameter logic [15:0] ADDR_FLT_FIRST  = 16'h0043
) (
    input  logic                  clk_100m,
    input  logic                  rst_syn,
    input  logic [N_CH-1:0]       flt_in,
    fault_monitor_regs_if.slave   wr_bus,
    output logic [31:0]           flt_live_reg,
    output logic [31:0]           flt_sticky_reg,
    output logic [31:0]           flt_mask_reg,
    output logic [31:0]           flt_pol_reg,
    output logic [31:0]           flt_first_reg,
    output logic                  flt_irq
);
    localparam int unsigned       IDX_W    = 5;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [N_CH-1:0]   CH_ONES  = '1;

    logic [N_CH-1:0]             sync1, sync2, asserted, live;
    logic [N_CH-1:0][DEB_W-1:0]  cnt;
    logic [N_CH-1:0]             sticky, mask, pol, sticky_nxt, rise;
    logic                        first_valid;
    logic [IDX_W-1:0]            first_idx, rise_idx;
    logic                        irq;
    logic                        wr_sticky, wr_mask, wr_pol, wr_first;
    logic [N_CH-1:0]             wr_data;
    logic                        unused_data_hi;

    // Write decode; only the low N_CH data bits reach any register
    assign wr_sticky      = wr_bus.data_mosi_rdy && (wr_bus.addr == ADDR_FLT_STICKY);
    assign wr_mask        = wr_bus.data_mosi_rdy && (wr_bus.addr == ADDR_FLT_MASK);
    assign wr_pol         = wr_bus.data_mosi_rdy && (wr_bus.addr == ADDR_FLT_POL);
    assign wr_first       = wr_bus.data_mosi_rdy && (wr_bus.addr == ADDR_FLT_FIRST);
    assign wr_data        = wr_bus.data_mosi[N_CH-1:0];
    assign unused_data_hi = ^wr_bus.data_mosi;

    assign asserted = sync2 ^ pol;

    // Two-flop synchroniser
    always_ff @(posedge clk_100m or posedge rst_syn) begin
        if (rst_syn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= flt_in;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: a new level must hold DEB_CYCLES consecutive cycles
    always_ff @(posedge clk_100m or posedge rst_syn) begin
        if (rst_syn) begin
            cnt  <= '0;
            live <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (asserted[i] == live[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    live[i] <= asserted[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Sticky update (set beats clear) and lowest newly-set unmasked channel
    always_comb begin
        sticky_nxt = sticky | live;
        if (wr_sticky) begin
            sticky_nxt = sticky_nxt & ~(wr_data & ~live);
        end
        rise     = sticky_nxt & ~sticky & ~mask;
        rise_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_100m or posedge rst_syn) begin
        if (rst_syn) begin
            sticky      <= '0;
            mask        <= CH_ONES;
            pol         <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            irq         <= 1'b0;
        end else begin
            sticky <= sticky_nxt;
            if (wr_mask) mask <= wr_data;
            if (wr_pol)  pol  <= wr_data;
            // A capture in the same cycle as a clearing write takes priority
            if (!first_valid && (|rise)) begin
                first_valid <= 1'b1;
                first_idx   <= rise_idx;
            end else if (wr_first) begin
                first_valid <= 1'b0;
                first_idx   <= '0;
            end
            irq <= |(sticky & ~mask);
        end
    end

    assign flt_live_reg   = 32'(live);
    assign flt_sticky_reg = 32'(sticky);
    assign flt_mask_reg   = 32'(mask);
    assign flt_pol_reg    = 32'(pol);
    assign flt_first_reg  = {first_valid, 26'd0, first_idx};
    assign flt_irq        = irq;
endmodule

// File: tb/tb_fault_monitor_regs.sv
// Bench for fault_monitor_regs: directed vector table, hand sequences and a randomized run
// checked every cycle against a sliding-window behavioural model.
module tb_fault_monitor_regs;
    localparam int unsigned NC  = 16;
    localparam int unsigned DEB = 4;
    localparam logic [15:0] A_STK = 16'h0040;
    localparam logic [15:0] A_MSK = 16'h0041;
    localparam logic [15:0] A_POL = 16'h0042;
    localparam logic [15:0] A_FST = 16'h0043;

    logic        clk_100m = 1'b0;
    logic        rst_syn;
    logic [15:0] flt;
    logic [3:0]  flt4;
    logic [31:0] live_o, sticky_o, mask_o, pol_o, first_o;
    logic        irq_o;
    logic [31:0] live4, sticky4, mask4, pol4, first4;
    logic        irq4;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100m = ~clk_100m;

    fault_monitor_regs_if bus ();
    fault_monitor_regs_if bus4 ();

    fault_monitor_regs #(.N_CH(NC), .DEB_W(8), .DEB_CYCLES(DEB)) dut (
        .clk_100m(clk_100m), .rst_syn(rst_syn), .flt_in(flt), .wr_bus(bus.slave),
        .flt_live_reg(live_o), .flt_sticky_reg(sticky_o), .flt_mask_reg(mask_o),
        .flt_pol_reg(pol_o), .flt_first_reg(first_o), .flt_irq(irq_o));

    fault_monitor_regs #(.N_CH(4), .DEB_W(8), .DEB_CYCLES(DEB)) dut4 (
        .clk_100m(clk_100m), .rst_syn(rst_syn), .flt_in(flt4), .wr_bus(bus4.slave),
        .flt_live_reg(live4), .flt_sticky_reg(sticky4), .flt_mask_reg(mask4),
        .flt_pol_reg(pol4), .flt_first_reg(first4), .flt_irq(irq4));

    // Behavioural model: a channel's live level flips once the last DEB
    // synchronised samples all disagree with it.
    logic [15:0]    m_s1, m_s2, m_live, m_sticky, m_mask, m_pol;
    logic           m_fv, m_irq;
    logic [4:0]     m_fidx;
    logic [DEB-1:0] m_win [NC];
    int             m_fill;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_live = '0; m_sticky = '0; m_pol = '0;
        m_mask = 16'hFFFF; m_fv = 1'b0; m_fidx = '0; m_irq = 1'b0; m_fill = 0;
        for (int c = 0; c < int'(NC); c++) m_win[c] = '0;
    endfunction

    function automatic void model_tick();
        logic [15:0]    asrt, n_live, n_sticky, rising, wd;
        logic           ws, wm, wp, wf;
        logic [DEB-1:0] ones, zeros;
        ones  = '1;
        zeros = '0;
        wd = bus.data_mosi[15:0];
        ws = bus.data_mosi_rdy && (bus.addr == A_STK);
        wm = bus.data_mosi_rdy && (bus.addr == A_MSK);
        wp = bus.data_mosi_rdy && (bus.addr == A_POL);
        wf = bus.data_mosi_rdy && (bus.addr == A_FST);
        asrt = m_s2 ^ m_pol;
        if (m_fill < int'(DEB)) m_fill++;
        n_live = m_live;
        for (int c = 0; c < int'(NC); c++) begin
            m_win[c] = {m_win[c][DEB-2:0], asrt[c]};
            if (m_fill >= int'(DEB) && m_win[c] == (m_live[c] ? zeros : ones))
                n_live[c] = ~m_live[c];
        end
        n_sticky = m_sticky | m_live;
        if (ws) n_sticky = n_sticky & ~(wd & ~m_live);
        rising = n_sticky & ~m_sticky & ~m_mask;
        if (!m_fv && rising != 16'h0) begin
            m_fv = 1'b1;
            for (int c = 0; c < int'(NC); c++) begin
                if (rising[c]) begin
                    m_fidx = 5'(c);
                    break;
                end
            end
        end else if (wf) begin
            m_fv   = 1'b0;
            m_fidx = '0;
        end
        m_irq = |(m_sticky & ~m_mask);
        if (wm) m_mask = wd;
        if (wp) m_pol = wd;
        m_sticky = n_sticky;
        m_live   = n_live;
        m_s2     = m_s1;
        m_s1     = flt;
    endfunction

    function automatic void check_model();
        check("mdl_live",   live_o,   {16'h0, m_live});
        check("mdl_sticky", sticky_o, {16'h0, m_sticky});
        check("mdl_mask",   mask_o,   {16'h0, m_mask});
        check("mdl_pol",    pol_o,    {16'h0, m_pol});
        check("mdl_first",  first_o,  {m_fv, 26'd0, m_fidx});
        check("mdl_irq",    32'(irq_o), 32'(m_irq));
    endfunction

    task automatic step();
        model_tick();
        @(posedge clk_100m);
        #1;
        check_model();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus.addr = a; bus.data_mosi = d; bus.data_mosi_rdy = 1'b1;
        step();
        bus.data_mosi_rdy = 1'b0;
    endtask

    task automatic wr4(input logic [15:0] a, input logic [31:0] d);
        bus4.addr = a; bus4.data_mosi = d; bus4.data_mosi_rdy = 1'b1;
        step();
        bus4.data_mosi_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_100m);
        rst_syn = 1'b1;
        bus.data_mosi_rdy = 1'b0;
        bus4.data_mosi_rdy = 1'b0;
        model_reset();
        @(negedge clk_100m);
        rst_syn = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pol;
        logic [15:0] mask;
        logic [15:0] flt;
        int          hold;
        logic [31:0] e_live;
        logic [31:0] e_sticky;
        logic [31:0] e_first;
        logic        e_irq;
    } vec_t;

    vec_t vecs [8];

    initial begin
        rst_syn = 1'b1;
        flt = '0; flt4 = '0;
        bus.addr = '0;  bus.data_mosi = '0;  bus.data_mosi_rdy = 1'b0;
        bus4.addr = '0; bus4.data_mosi = '0; bus4.data_mosi_rdy = 1'b0;
        model_reset();

        // {pol, mask, flt, cycles from flt applied, live, sticky, first, irq}
        vecs[0] = '{16'h0000, 16'h0000, 16'h0008,  5, 32'h0,    32'h0,    32'h0,        1'b0};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0008,  6, 32'h8,    32'h0,    32'h0,        1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0008,  7, 32'h8,    32'h8,    32'h80000003, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0008,  8, 32'h8,    32'h8,    32'h80000003, 1'b1};
        vecs[4] = '{16'h0000, 16'h0004, 16'h0024,  8, 32'h24,   32'h24,   32'h80000005, 1'b1};
        vecs[5] = '{16'h0001, 16'hFFFF, 16'h0000, 10, 32'h1,    32'h1,    32'h0,        1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 16'hFFFF, 10, 32'hFFFF, 32'hFFFF, 32'h80000000, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0000, 16'h00FF, 10, 32'h0,    32'h0,    32'h0,        1'b0};

        do_reset();
        check("rst_live", live_o, 32'h0);
        check("rst_mask", mask_o, 32'h0000FFFF);
        check("rst_mask4", mask4, 32'h0000000F);
        check("rst_first", first_o, 32'h0);

        foreach (vecs[v]) begin
            do_reset();
            flt = vecs[v].flt;
            wr(A_POL, {16'h0, vecs[v].pol});
            wr(A_MSK, {16'h0, vecs[v].mask});
            repeat (vecs[v].hold - 2) step();
            check($sformatf("vec%0d_live", v),   live_o,     vecs[v].e_live);
            check($sformatf("vec%0d_sticky", v), sticky_o,   vecs[v].e_sticky);
            check($sformatf("vec%0d_first", v),  first_o,    vecs[v].e_first);
            check($sformatf("vec%0d_irq", v),    32'(irq_o), 32'(vecs[v].e_irq));
        end

        // Glitch shorter than the debounce window is rejected; a full window is accepted
        do_reset();
        flt = '0;
        wr(A_MSK, 32'h0);
        flt = 16'h0001; repeat (3) step();
        flt = 16'h0000; repeat (8) step();
        check("glitch_live", live_o, 32'h0);
        check("glitch_sticky", sticky_o, 32'h0);
        check("glitch_irq", 32'(irq_o), 32'h0);
        flt = 16'h0001; repeat (4) step();
        flt = 16'h0000; repeat (2) step();
        check("deb4_live", live_o, 32'h1);

        // W1C cannot clear a live fault; clears once the fault has debounced away
        do_reset();
        flt = '0;
        wr(A_MSK, 32'h0);
        flt = 16'h0008; repeat (9) step();
        check("w1c_pre_irq", 32'(irq_o), 32'h1);
        wr(A_STK, 32'h8);
        check("w1c_live_hold", sticky_o, 32'h8);
        flt = 16'h0000; repeat (DEB + 3) step();
        check("w1c_live_gone", live_o, 32'h0);
        wr(A_STK, 32'h8);
        check("w1c_clear", sticky_o, 32'h0);
        check("w1c_irq_lag", 32'(irq_o), 32'h1);
        step();
        check("w1c_irq_off", 32'(irq_o), 32'h0);
        check("w1c_first_kept", first_o, 32'h80000003);
        wr(A_FST, 32'h0);
        check("first_clear", first_o, 32'h0);

        // Masking an active sticky bit drops the irq one cycle after the mask update
        do_reset();
        flt = '0;
        wr(A_MSK, 32'h4);
        flt = 16'h0024; repeat (9) step();
        check("msk_sticky", sticky_o, 32'h24);
        check("msk_first", first_o, 32'h80000005);
        wr(A_MSK, 32'h24);
        check("msk_reg", mask_o, 32'h24);
        check("msk_irq_lag", 32'(irq_o), 32'h1);
        step();
        check("msk_irq_off", 32'(irq_o), 32'h0);
        wr(A_MSK, 32'hFFFFFFFF);
        check("msk_hi_bits", mask_o, 32'h0000FFFF);
        bus.addr = A_MSK; bus.data_mosi = 32'h0; step();
        check("msk_no_strobe", mask_o, 32'h0000FFFF);

        // Async reset in the middle of a falling debounce
        do_reset();
        flt = '0;
        wr(A_MSK, 32'h0);
        flt = 16'hFFFF; repeat (10) step();
        check("ar_sticky_full", sticky_o, 32'hFFFF);
        flt = 16'h0000; repeat (3) step();
        check("ar_live_mid", live_o, 32'hFFFF);
        #3;
        rst_syn = 1'b1;
        model_reset();
        #1;
        check("ar_live", live_o, 32'h0);
        check("ar_sticky", sticky_o, 32'h0);
        check("ar_mask", mask_o, 32'h0000FFFF);
        check("ar_first", first_o, 32'h0);
        check("ar_irq", 32'(irq_o), 32'h0);
        @(negedge clk_100m);
        rst_syn = 1'b0;
        flt = 16'hFFFF; repeat (5) step();
        check("ar_recount_early", live_o, 32'h0);
        step();
        check("ar_recount_done", live_o, 32'hFFFF);

        // Narrow build ignores bits above its channel count
        wr4(A_MSK, 32'hFFFFFFFF);
        check("n4_mask", mask4, 32'h0000000F);
        wr4(A_POL, 32'hFFFFFFFF);
        check("n4_pol", pol4, 32'h0000000F);

        // Randomized traffic against the model
        do_reset();
        flt = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < int'(NC); c++)
                if ($urandom_range(0, 9) == 0) flt[c] = ~flt[c];
            bus.data_mosi     = $urandom;
            bus.data_mosi_rdy = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0: bus.addr = A_STK;
                1: bus.addr = A_MSK;
                2: bus.addr = A_POL;
                3: bus.addr = A_FST;
                4: bus.addr = 16'h0044;
                default: bus.addr = 16'h1040;
            endcase
            step();
        end
        bus.data_mosi_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
